// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared encodings and constants for the multiply/divide sequencer
package multdiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_RUN  = 2'b10,
    S_FIX  = 2'b11
  } state_e;

  localparam logic [MD_WIDTH-1:0] DIV0_LO = '1;

endpackage

// File: rtl/multdiv_step.sv
// rtl/multdiv_step.sv - one combinational shift-add (multiply) or restoring-subtract (divide) step
import multdiv_pkg::*;

module multdiv_step #(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   upper;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    // Upper half after the left shift needs one extra bit before the compare.
    upper = acc_in[2*WIDTH-1:WIDTH-1];
    diff  = upper[WIDTH-1:0] - operand;
    if (is_div) begin
      if (upper >= {1'b0, operand}) begin
        acc_out = {diff, acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {acc_in[2*WIDTH-2:0], 1'b0};
      end
    end else if (acc_in[0]) begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end else begin
      acc_out = {1'b0, acc_in[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - MULT/DIV sequencer FSM owning HI/LO with MFHI/MFLO stall generation
import multdiv_pkg::*;

module multdiv_ctrl #(
  parameter int WIDTH  = MD_WIDTH,
  parameter int ITER_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mf_req,
  input  logic             mt_we,
  input  logic             mt_sel,
  input  logic [WIDTH-1:0] mt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int W2 = 2 * WIDTH;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, opnd_q, opnd_d;
  logic [W2-1:0]     acc_q, acc_d, step_acc, prod_fix;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic              sgn_p_q, sgn_p_d, sgn_r_q, sgn_r_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;
  logic              is_div, is_signed, sa, sb;
  logic [WIDTH-1:0]  mag_a, mag_b;

  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign sa        = is_signed && a_q[WIDTH-1];
  assign sb        = is_signed && b_q[WIDTH-1];
  assign mag_a     = sa ? -a_q : a_q;
  assign mag_b     = sb ? -b_q : b_q;
  assign prod_fix  = sgn_p_q ? -acc_q : acc_q;

  multdiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc_q),
    .operand (opnd_q),
    .is_div  (is_div),
    .acc_out (step_acc)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sgn_p_d = sgn_p_q;
    sgn_r_d = sgn_r_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    // MTHI/MTLO lands first so that a same-cycle FIX write overrides it.
    if (mt_we) begin
      if (mt_sel) hi_d = mt_data;
      else        lo_d = mt_data;
    end
    if (start) begin
      state_d = S_PREP;
      op_d    = op;
      a_d     = rs_val;
      b_d     = rt_val;
    end else begin
      case (state_q)
        S_PREP: begin
          sgn_p_d = sa ^ sb;
          sgn_r_d = sa;
          // Divide shifts the dividend up from the low half; multiply walks the multiplier out of it.
          if (is_div) begin
            opnd_d = mag_b;
            acc_d  = {{WIDTH{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {{WIDTH{1'b0}}, mag_b};
          end
          cnt_d   = '0;
          state_d = S_RUN;
        end
        S_RUN: begin
          acc_d = step_acc;
          cnt_d = cnt_q + ITER_W'(1);
          if (cnt_q == ITER_W'(WIDTH - 1)) state_d = S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            if (b_q == '0) begin
              lo_d = WIDTH'(DIV0_LO);
              hi_d = a_q;
            end else begin
              lo_d = sgn_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
              hi_d = sgn_r_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
            end
          end else begin
            hi_d = prod_fix[W2-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sgn_p_q <= 1'b0;
      sgn_r_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sgn_p_q <= sgn_p_d;
      sgn_r_q <= sgn_r_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign busy  = (state_q != S_IDLE);
  assign stall = mf_req & busy;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - directed and randomized checks of multdiv_ctrl against an arithmetic model
module tb_multdiv_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, mf_req, mt_we, mt_sel;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, mt_data;
  logic [31:0] hi, lo;
  logic        busy, stall, done;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  multdiv_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .mf_req  (mf_req),
    .mt_we   (mt_we),
    .mt_sel  (mt_sel),
    .mt_data (mt_data),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .stall   (stall),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0;
    l = '0;
    case (o)
      2'b00: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      2'b10: begin
        if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
        else begin l = 32'(sa / sb); h = 32'(sa % sb); end
      end
      default: begin
        if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int mf_from);
    logic [31:0] eh, el;
    model(o, a, b, eh, el);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      tick();
      start  = 1'b0;
      mf_req = (mf_from > 0) && (c >= mf_from);
      #1;
      if (c < 35) begin
        chk("busy", {31'b0, busy}, 32'd1);
        chk("done_early", {31'b0, done}, 32'd0);
        if (mf_from > 0 && c >= mf_from) chk("stall", {31'b0, stall}, 32'd1);
      end else begin
        chk("done", {31'b0, done}, 32'd1);
        chk("busy_end", {31'b0, busy}, 32'd0);
        chk("stall_end", {31'b0, stall}, 32'd0);
        chk("hi", hi, eh);
        chk("lo", lo, el);
      end
    end
    mf_req = 1'b0;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          sel;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    mf_req = 1'b1; mt_we = 1'b0; mt_sel = 1'b0; mt_data = '0;
    tick(); tick();
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    rst = 1'b0; mf_req = 1'b0;
    tick();

    run_op(2'b01, 32'd5040, 32'd8, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 5);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'b11, 32'd7, 32'd0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'd123, 32'd0, 0);
    tick();
    chk("done_one_cycle", {31'b0, done}, 32'd0);

    // MTHI mid-flight is visible, then the FIX write beats a same-cycle MTLO.
    op = 2'b01; rs_val = 32'd9; rt_val = 32'd9; start = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      tick();
      start = 1'b0;
      mt_we = (c == 15) || (c == 34);
      mt_sel = (c == 15);
      mt_data = (c == 15) ? 32'h0000_ABCD : 32'h0000_5555;
      if (c == 16) chk("mthi_busy", hi, 32'h0000_ABCD);
      if (c == 35) begin
        chk("fix_wins_lo", lo, 32'd81);
        chk("fix_wins_hi", hi, 32'd0);
        chk("fix_done", {31'b0, done}, 32'd1);
      end
    end
    mt_we = 1'b0;

    // Restart at cycle 10 discards the first operation.
    op = 2'b11; rs_val = 32'd1000; rt_val = 32'd7; start = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      tick();
      start = (c == 10);
      if (c == 10) begin op = 2'b01; rs_val = 32'd2; rt_val = 32'd3; end
      if (c < 45) chk("abort_no_done", {31'b0, done}, 32'd0);
      else begin
        chk("abort_done", {31'b0, done}, 32'd1);
        chk("abort_lo", lo, 32'd6);
        chk("abort_hi", hi, 32'd0);
      end
    end

    // Reset mid-DIV, then MTLO.
    op = 2'b10; rs_val = 32'hFFFF_FF9C; rt_val = 32'd3; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = 1'b0;
      rst = (c == 20);
      mt_we = (c == 21);
      mt_sel = 1'b0;
      mt_data = 32'h0000_0168;
      if (c == 21) begin
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
      end
      if (c == 22) chk("mtlo_after_rst", lo, 32'h0000_0168);
      if (c >= 21) chk("rst_no_done", {31'b0, done}, 32'd0);
    end
    rst = 1'b0; mt_we = 1'b0;

    for (int i = 0; i < 14; i++) begin
      sel = int'($urandom_range(0, 3));
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 1) begin ra = $urandom_range(0, 2000); rb = $urandom_range(1, 50); end
      if (sel == 2) rb = 32'd0;
      if (sel == 3) begin ra = -($urandom_range(0, 5000)); rb = -($urandom_range(1, 40)); end
      run_op(ro, ra, rb, (i % 3 == 0) ? 3 : 0);
    end
    tick();
    chk("final_done_low", {31'b0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
